// File: rtl/div_unit.sv
// RV32M divide/remainder unit: restoring radix-2 divider, one quotient bit per cycle.
// Divide-by-zero and signed overflow bypass the iteration and complete on the next cycle.
module div_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] rs1v,
  input  logic [31:0] rs2v,
  input  logic [4:0]  rd_in,
  input  logic        kill,
  output logic        busy,
  output logic        we,
  output logic [4:0]  rd,
  output logic [31:0] rrd
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 5;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [XLEN-1:0]   quo;
  logic [XLEN-1:0]   rem;
  logic [XLEN-1:0]   dvs;
  logic              is_rem;
  logic              neg_q;
  logic              neg_r;
  logic [4:0]        rd_l;
  logic              we_q;

  logic              sgn;
  logic [XLEN-1:0]   a_mag;
  logic [XLEN-1:0]   b_mag;
  logic              div_zero;
  logic              ovf;
  logic [XLEN-1:0]   fast_res;
  logic [XLEN:0]     rem_sh;
  logic [XLEN:0]     diff;
  logic              borrow;
  logic [XLEN:0]     rem_nx;
  logic [XLEN-1:0]   quo_nx;
  logic [XLEN-1:0]   q_fix;
  logic [XLEN-1:0]   r_fix;
  logic [XLEN-1:0]   calc_res;
  logic              unused_rem_msb;

  // Request decode: operand magnitudes and fast-path detection.
  always_comb begin
    sgn      = ~op[0];
    a_mag    = (sgn && rs1v[XLEN-1]) ? XLEN'(-rs1v) : rs1v;
    b_mag    = (sgn && rs2v[XLEN-1]) ? XLEN'(-rs2v) : rs2v;
    div_zero = (rs2v == '0);
    ovf      = sgn && (rs1v == 32'h8000_0000) && (rs2v == 32'hFFFF_FFFF);
    if (div_zero) fast_res = op[1] ? rs1v : '1;
    else          fast_res = op[1] ? '0 : 32'h8000_0000;
  end

  // One restoring step on the 33-bit partial remainder, plus final sign fix-up.
  always_comb begin
    rem_sh         = {rem, quo[XLEN-1]};
    {borrow, diff} = {1'b0, rem_sh} - {2'b00, dvs};
    rem_nx         = borrow ? rem_sh : diff;
    quo_nx         = {quo[XLEN-2:0], ~borrow};
    q_fix          = neg_q ? XLEN'(-quo_nx) : quo_nx;
    r_fix          = neg_r ? XLEN'(-rem_nx[XLEN-1:0]) : rem_nx[XLEN-1:0];
    calc_res       = is_rem ? r_fix : q_fix;
    unused_rem_msb = rem_nx[XLEN];
  end

  // Kill must suppress a write even in the DONE cycle itself.
  assign we = we_q & ~kill;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      quo    <= '0;
      rem    <= '0;
      dvs    <= '0;
      is_rem <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      rd_l   <= '0;
      busy   <= 1'b0;
      we_q   <= 1'b0;
      rd     <= '0;
      rrd    <= '0;
    end else if (kill) begin
      state <= IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      we_q  <= 1'b0;
      rd    <= '0;
      rrd   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            is_rem <= op[1];
            neg_q  <= sgn && (rs1v[XLEN-1] ^ rs2v[XLEN-1]);
            neg_r  <= sgn && rs1v[XLEN-1];
            rd_l   <= rd_in;
            quo    <= a_mag;
            dvs    <= b_mag;
            rem    <= '0;
            cnt    <= '0;
            busy   <= 1'b1;
            if (div_zero || ovf) begin
              state <= DONE;
              rrd   <= fast_res;
              rd    <= rd_in;
              we_q  <= (rd_in != '0);
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          quo <= quo_nx;
          rem <= rem_nx[XLEN-1:0];
          cnt <= CNT_W'(cnt + 1'b1);
          if (cnt == CNT_W'(XLEN - 1)) begin
            state <= DONE;
            rrd   <= calc_res;
            rd    <= rd_l;
            we_q  <= (rd_l != '0);
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          we_q  <= 1'b0;
          rd    <= '0;
          rrd   <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
